// File: rtl/spi_reg_publisher.sv
// Change-driven publisher: scans sensor channels round-robin and writes a
// channel into the SPI slave register bank only when it differs from the
// value last published. It also supports an enable mask, periodic forced
// refresh and a coherent snapshot pass.
module spi_reg_publisher #(
  parameter int                N_CH           = 3,
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                REFRESH_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic                     snap,
  output logic                     Data_WE,
  output logic [ADDR_W-1:0]        Data_Addr,
  output logic [DATA_W-1:0]        Data_Write,
  output logic                     snap_busy,
  output logic                     snap_done,
  output logic [15:0]              write_count
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  // ST_DONE is the extra clock after the last snapshot slot that emits snap_done.
  typedef enum logic [1:0] {ST_LIVE, ST_SNAP, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   prev_q [N_CH];
  logic [DATA_W-1:0]   prev_d [N_CH];
  logic [DATA_W-1:0]   snap_val_q [N_CH];
  logic [DATA_W-1:0]   snap_val_d [N_CH];
  logic [N_CH-1:0]     pend_q, pend_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         wcnt_q, wcnt_d;
  logic                refresh_tick;
  logic [ADDR_W-1:0]   slot_addr;
  logic [DATA_W-1:0]   ch_arr [N_CH];

  // Unpack the flat channel bus into one word per channel.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign ch_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
  end

  // Register address for the current slot; wraps modulo 2^ADDR_W.
  assign slot_addr = BASE_ADDR + ADDR_W'(idx_q);

  if (REFRESH_CYCLES > 0) begin : g_refresh
    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);
    logic [RC_W-1:0] rc_q;

    // Free-running refresh period counter; terminal count marks every channel stale.
    always_ff @(posedge clk) begin
      if (reset) begin
        rc_q <= '0;
      end else if (rc_q == RC_LAST) begin
        rc_q <= '0;
      end else begin
        rc_q <= rc_q + 1'b1;
      end
    end

    assign refresh_tick = (rc_q == RC_LAST);
  end else begin : g_no_refresh
    assign refresh_tick = 1'b0;
  end

  // Slot decision: publish on change/refresh in LIVE, replay the snapshot in SNAP.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prev_d     = prev_q;
    snap_val_d = snap_val_q;
    pend_d     = pend_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    wcnt_d     = wcnt_q;

    unique case (state_q)
      ST_LIVE: begin
        pend_d[idx_q] = 1'b0;
        if (ch_enable[idx_q] && ((ch_arr[idx_q] != prev_q[idx_q]) || pend_q[idx_q])) begin
          prev_d[idx_q] = ch_arr[idx_q];
          we_d          = 1'b1;
          addr_d        = slot_addr;
          wdata_d       = ch_arr[idx_q];
          wcnt_d        = wcnt_q + 16'd1;
        end
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        // The live slot on the request edge still runs; the pass starts next edge.
        if (snap) begin
          snap_val_d = ch_arr;
          state_d    = ST_SNAP;
          idx_d      = '0;
        end
      end
      ST_SNAP: begin
        if (ch_enable[idx_q]) begin
          prev_d[idx_q] = snap_val_q[idx_q];
          we_d          = 1'b1;
          addr_d        = slot_addr;
          wdata_d       = snap_val_q[idx_q];
          wcnt_d        = wcnt_q + 16'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_LIVE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_LIVE;
        idx_d   = '0;
      end
    endcase

    // A refresh request outranks the per-slot clear.
    if (refresh_tick) begin
      pend_d = '1;
    end

    busy_d = (state_d != ST_LIVE);
  end

  // State and output registers; reset aborts any snapshot pass silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LIVE;
      idx_q   <= '0;
      pend_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        prev_q[k]     <= '0;
        snap_val_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
      prev_q     <= prev_d;
      snap_val_q <= snap_val_d;
    end
  end

  assign Data_WE     = we_q;
  assign Data_Addr   = addr_q;
  assign Data_Write  = wdata_q;
  assign snap_busy   = busy_q;
  assign snap_done   = done_q;
  assign write_count = wcnt_q;

endmodule

// File: tb/tb_spi_reg_publisher.sv
// Bench for spi_reg_publisher: two instances (no refresh / 16-clock refresh
// with a wrapping base address) checked every cycle against a behavioural
// model, plus directed literal checks from the test plan.
module tb_spi_reg_publisher;
  localparam int N = 3;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFE;
  localparam int REF_A = 0;
  localparam int REF_B = 16;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [95:0] data_a, data_b;
  logic [2:0] en_a, en_b;
  logic snap_a, snap_b;
  logic we_a, we_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] addr_a, addr_b, wd_a, wd_b;
  logic [15:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  spi_reg_publisher #(.N_CH(N), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE_A), .REFRESH_CYCLES(REF_A)) dut_a (
    .clk(clk), .reset(rst_a), .ch_data(data_a), .ch_enable(en_a), .snap(snap_a),
    .Data_WE(we_a), .Data_Addr(addr_a), .Data_Write(wd_a),
    .snap_busy(busy_a), .snap_done(done_a), .write_count(cnt_a));

  spi_reg_publisher #(.N_CH(N), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE_B), .REFRESH_CYCLES(REF_B)) dut_b (
    .clk(clk), .reset(rst_b), .ch_data(data_b), .ch_enable(en_b), .snap(snap_b),
    .Data_WE(we_b), .Data_Addr(addr_b), .Data_Write(wd_b),
    .snap_busy(busy_b), .snap_done(done_b), .write_count(cnt_b));

  // ---------------- behavioural model ----------------
  int          m_ptr [2];
  logic [31:0] m_shadow [2][N];
  bit          m_stale [2][N];
  logic [31:0] m_pass_val [2][N];
  int          m_pass_pos [2];   // -1: no pass; 0..N-1: next slot; N: done clock
  int          m_cycles [2];
  logic        e_we [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wd [2];
  logic        e_busy [2];
  logic        e_done [2];
  logic [15:0] e_cnt [2];

  task automatic publish(input int k, input int c, input logic [31:0] v, input logic [31:0] base);
    e_we[k] = 1'b1;
    e_addr[k] = base + c;
    e_wd[k] = v;
    m_shadow[k][c] = v;
    e_cnt[k] = e_cnt[k] + 16'd1;
  endtask

  task automatic model_step(input int k, input bit rst, input logic [95:0] d, input logic [2:0] en,
                            input bit sn, input int period, input logic [31:0] base);
    int c;
    bit tick;
    logic [31:0] cur;
    if (rst) begin
      m_ptr[k] = 0; m_pass_pos[k] = -1; m_cycles[k] = 0;
      for (int j = 0; j < N; j++) begin
        m_shadow[k][j] = 32'h0; m_stale[k][j] = 1'b0; m_pass_val[k][j] = 32'h0;
      end
      e_we[k] = 1'b0; e_addr[k] = 32'h0; e_wd[k] = 32'h0;
      e_busy[k] = 1'b0; e_done[k] = 1'b0; e_cnt[k] = 16'h0;
      return;
    end
    tick = (period > 0) && ((m_cycles[k] % period) == period - 1);
    m_cycles[k]++;
    e_we[k] = 1'b0;
    e_done[k] = 1'b0;
    if (m_pass_pos[k] < 0) begin
      c = m_ptr[k];
      cur = d[c*32 +: 32];
      if (en[c] && (cur != m_shadow[k][c] || m_stale[k][c])) publish(k, c, cur, base);
      m_stale[k][c] = 1'b0;
      m_ptr[k] = (c + 1) % N;
      if (sn) begin
        for (int j = 0; j < N; j++) m_pass_val[k][j] = d[j*32 +: 32];
        m_pass_pos[k] = 0;
        m_ptr[k] = 0;
      end
    end else if (m_pass_pos[k] < N) begin
      c = m_pass_pos[k];
      if (en[c]) publish(k, c, m_pass_val[k][c], base);
      m_pass_pos[k]++;
    end else begin
      e_done[k] = 1'b1;
      m_pass_pos[k] = -1;
      m_ptr[k] = 0;
    end
    if (tick) for (int j = 0; j < N; j++) m_stale[k][j] = 1'b1;
    e_busy[k] = (m_pass_pos[k] >= 0);
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, data_a, en_a, snap_a, REF_A, BASE_A);
    model_step(1, rst_b, data_b, en_b, snap_b, REF_B, BASE_B);
  end

  // ---------------- per-cycle compare ----------------
  task automatic compare(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic busy, input logic done, input logic [15:0] cnt);
    n_checks++;
    if (we !== e_we[k] || addr !== e_addr[k] || wd !== e_wd[k] || busy !== e_busy[k] ||
        done !== e_done[k] || cnt !== e_cnt[k]) begin
      n_fail++;
      $display("FAIL cycle_cmp dut%0d t=%0t: got we=%b addr=%h data=%h busy=%b done=%b cnt=%0d, expected we=%b addr=%h data=%h busy=%b done=%b cnt=%0d",
               k, $time, we, addr, wd, busy, done, cnt,
               e_we[k], e_addr[k], e_wd[k], e_busy[k], e_done[k], e_cnt[k]);
    end
    if (we === 1'b1) $display("dut%0d write addr=%h data=%h count=%0d", k, addr, wd, cnt);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare(0, we_a, addr_a, wd_a, busy_a, done_a, cnt_a);
      compare(1, we_b, addr_b, wd_b, busy_b, done_b, cnt_b);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic wait_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input int max, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (k == 0) found = (we_a === 1'b1) && (addr_a === addr) && (wd_a === data);
      else        found = (we_b === 1'b1) && (addr_b === addr) && (wd_b === data);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: no write of %h to addr %h within %0d clocks", name, data, addr, max);
    end
  endtask

  task automatic count_a(input int cycles, output int n_we, output int n_done);
    n_we = 0; n_done = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (we_a === 1'b1) n_we++;
      if (done_a === 1'b1) n_done++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nw, nd;
    logic [15:0] prev_cnt;
    rst_a = 1'b1; rst_b = 1'b1;
    data_a = '0; data_b = '0;
    en_a = 3'b111; en_b = 3'b111;
    snap_a = 1'b0; snap_b = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_we", {31'b0, we_a}, 32'h0);
    check("reset_addr", addr_a, 32'h0);
    check("reset_data", wd_a, 32'h0);
    check("reset_busy_done", {30'b0, busy_a, done_a}, 32'h0);
    check("reset_cnt", {16'b0, cnt_a}, 32'h0);
    check("reset_cnt_b", {16'b0, cnt_b}, 32'h0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Static zero data: no writes at all.
    count_a(100, nw, nd);
    check("idle_writes", nw, 0);
    check("idle_cnt", {16'b0, cnt_a}, 32'h0);

    // Single channel change.
    data_a[63:32] = 32'h0001_0002;
    wait_write(0, 32'h1, 32'h0001_0002, 3, "ch1_write");
    count_a(10, nw, nd);
    check("ch1_no_repeat", nw, 0);
    check("ch1_cnt", {16'b0, cnt_a}, 32'd1);

    // All three change together.
    data_a = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001};
    count_a(4, nw, nd);
    check("all3_writes", nw, 3);
    check("all3_cnt", {16'b0, cnt_a}, 32'd4);

    // Masked channel.
    en_a = 3'b101;
    data_a[63:32] = 32'h5555_0001;
    count_a(8, nw, nd);
    check("masked_writes", nw, 0);
    en_a = 3'b111;
    wait_write(0, 32'h1, 32'h5555_0001, 3, "unmask_write");
    check("unmask_cnt", {16'b0, cnt_a}, 32'd5);

    // Snapshot pass with a live change and a second snap during the pass.
    data_a = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    count_a(4, nw, nd);
    check("pre_snap_cnt", {16'b0, cnt_a}, 32'd8);
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    check("snap_busy_rise", {30'b0, busy_a, we_a}, 32'h2);
    @(negedge clk);
    check("snap_slot0", {we_a, addr_a[2:0], wd_a}, {1'b1, 3'd0, 32'hAAAA_0000});
    data_a[31:0] = 32'hDDDD_0003;
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    check("snap_slot1", {we_a, addr_a[2:0], wd_a}, {1'b1, 3'd1, 32'hBBBB_0001});
    @(negedge clk);
    check("snap_slot2", {we_a, addr_a[2:0], wd_a}, {1'b1, 3'd2, 32'hCCCC_0002});
    check("snap_busy_last", {31'b0, busy_a}, 32'h1);
    @(negedge clk);
    check("snap_done", {29'b0, done_a, busy_a, we_a}, 32'h4);
    wait_write(0, 32'h0, 32'hDDDD_0003, 3, "post_snap_live");
    count_a(8, nw, nd);
    check("second_snap_ignored", nd, 0);
    check("post_snap_cnt", {16'b0, cnt_a}, 32'd12);

    // Reset in the middle of a pass.
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midrst_outputs", {29'b0, we_a, busy_a, done_a}, 32'h0);
    check("midrst_addr_data", addr_a | wd_a, 32'h0);
    check("midrst_cnt", {16'b0, cnt_a}, 32'h0);
    count_a(8, nw, nd);
    check("midrst_no_done", nd, 0);

    // Refresh instance: wrapping address, then per-period write growth.
    data_b = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    wait_write(1, 32'h0000_0000, 32'h3333_0003, 3, "b_wrap_addr");
    repeat (20) @(negedge clk);
    prev_cnt = cnt_b;
    for (int p = 0; p < 4; p++) begin
      repeat (16) @(negedge clk);
      check("b_refresh_delta3", {16'b0, cnt_b - prev_cnt}, 32'd3);
      prev_cnt = cnt_b;
    end
    en_b = 3'b011;
    repeat (16) @(negedge clk);
    prev_cnt = cnt_b;
    for (int p = 0; p < 3; p++) begin
      repeat (16) @(negedge clk);
      check("b_refresh_delta2", {16'b0, cnt_b - prev_cnt}, 32'd2);
      prev_cnt = cnt_b;
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
